// File: rtl/ship_motion_ctrl.sv
// ship_motion_ctrl
//   Game-state stage feeding the VGA renderer. Decodes PS/2 arrow-key
//   make/break sequences into four held key flags, and on each rising edge
//   of the frame interrupt moves the spaceship (clamped to the screen) and
//   steps the planet leftward every PLANET_DIV frames, wrapping it back to
//   the right edge with a new row.
//
//   Ports
//     clk          system clock (shared with the renderer)
//     rst_n        asynchronous active-low reset
//     scan_code    PS/2 byte, qualified by scan_valid
//     scan_valid   one-cycle strobe per received byte
//     vsync_irq    frame interrupt level, synchronous to clk
//     spaceship_x  ship left column
//     spaceship_y  ship top row
//     planet_x     planet left column
//     planet_y     planet top row
//     frame_done   one-cycle pulse the cycle after each position update
//
//   Scan decoder states
//     state     | meaning
//     ----------+---------------------------------------------
//     S_IDLE    | waiting for a new code sequence
//     S_EXT     | E0 seen, next byte is an extended make code
//     S_EXT_BRK | E0 F0 seen, next byte is an extended break
//     S_BRK     | F0 seen, next byte is a non-extended break (discarded)
`timescale 1ns/1ps

module ship_motion_ctrl #(
    parameter int SIZE          = 16,
    parameter int HD            = 640,
    parameter int VD            = 480,
    parameter int SHIP_SPEED    = 2,
    parameter int PLANET_SPEED  = 1,
    parameter int PLANET_DIV    = 2,
    parameter int PLANET_Y_STEP = 97
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       vsync_irq,
    output logic [9:0] spaceship_x,
    output logic [9:0] spaceship_y,
    output logic [9:0] planet_x,
    output logic [9:0] planet_y,
    output logic       frame_done
);

    localparam logic [7:0] CODE_EXT  = 8'hE0;
    localparam logic [7:0] CODE_BRK  = 8'hF0;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam logic [10:0] X_MAX      = 11'(HD - SIZE);
    localparam logic [10:0] Y_MAX      = 11'(VD - SIZE);
    localparam logic [10:0] SHIP_SPD   = 11'(SHIP_SPEED);
    localparam logic [9:0]  SHIP_SPD10 = 10'(SHIP_SPEED);
    localparam logic [10:0] PLN_SPD    = 11'(PLANET_SPEED);
    localparam logic [9:0]  PLN_SPD10  = 10'(PLANET_SPEED);
    localparam logic [10:0] PLN_Y_STEP = 11'(PLANET_Y_STEP);
    localparam logic [9:0]  Y_WRAP10   = 10'(VD - SIZE + 1);

    localparam int              CNT_W    = (PLANET_DIV > 1) ? $clog2(PLANET_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PLANET_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_EXT_BRK,
        S_BRK
    } dec_state_t;

    dec_state_t       dec_state;
    logic             key_up;
    logic             key_down;
    logic             key_left;
    logic             key_right;
    logic             vsync_q;
    logic             vsync_rise;
    logic [CNT_W-1:0] frame_cnt;

    // ------------------------------------------------------------------
    // Scan decoder and key flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_state <= S_IDLE;
            key_up    <= 1'b0;
            key_down  <= 1'b0;
            key_left  <= 1'b0;
            key_right <= 1'b0;
        end else if (scan_valid) begin
            case (dec_state)
                S_IDLE: begin
                    if (scan_code == CODE_EXT)
                        dec_state <= S_EXT;
                    else if (scan_code == CODE_BRK)
                        dec_state <= S_BRK;
                    else
                        dec_state <= S_IDLE;
                end
                S_EXT: begin
                    if (scan_code == CODE_BRK) begin
                        dec_state <= S_EXT_BRK;
                    end else begin
                        dec_state <= S_IDLE;
                        case (scan_code)
                            KEY_UP:    key_up    <= 1'b1;
                            KEY_DOWN:  key_down  <= 1'b1;
                            KEY_LEFT:  key_left  <= 1'b1;
                            KEY_RIGHT: key_right <= 1'b1;
                            default:   ;
                        endcase
                    end
                end
                S_EXT_BRK: begin
                    dec_state <= S_IDLE;
                    case (scan_code)
                        KEY_UP:    key_up    <= 1'b0;
                        KEY_DOWN:  key_down  <= 1'b0;
                        KEY_LEFT:  key_left  <= 1'b0;
                        KEY_RIGHT: key_right <= 1'b0;
                        default:   ;
                    endcase
                end
                S_BRK:   dec_state <= S_IDLE;
                default: dec_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-position arithmetic. Sums are 11 bits so the clamp compare sees
    // any carry out of the 10-bit coordinate.
    // ------------------------------------------------------------------
    logic [10:0] x_inc;
    logic [10:0] y_inc;
    logic [10:0] py_inc;
    logic [9:0]  ship_x_nxt;
    logic [9:0]  ship_y_nxt;
    logic [9:0]  planet_x_nxt;
    logic [9:0]  planet_y_nxt;

    assign x_inc  = {1'b0, spaceship_x} + SHIP_SPD;
    assign y_inc  = {1'b0, spaceship_y} + SHIP_SPD;
    assign py_inc = {1'b0, planet_y} + PLN_Y_STEP;
    assign vsync_rise = vsync_irq & ~vsync_q;

    always_comb begin
        ship_x_nxt = spaceship_x;
        if (key_right && !key_left)
            ship_x_nxt = (x_inc > X_MAX) ? X_MAX[9:0] : x_inc[9:0];
        else if (key_left && !key_right)
            ship_x_nxt = ({1'b0, spaceship_x} < SHIP_SPD) ? 10'd0 : spaceship_x - SHIP_SPD10;
    end

    always_comb begin
        ship_y_nxt = spaceship_y;
        if (key_down && !key_up)
            ship_y_nxt = (y_inc > Y_MAX) ? Y_MAX[9:0] : y_inc[9:0];
        else if (key_up && !key_down)
            ship_y_nxt = ({1'b0, spaceship_y} < SHIP_SPD) ? 10'd0 : spaceship_y - SHIP_SPD10;
    end

    // The wrapped row is always below 1024, so the 10-bit subtraction of
    // the low bits gives the exact result.
    always_comb begin
        planet_x_nxt = planet_x;
        planet_y_nxt = planet_y;
        if ({1'b0, planet_x} >= PLN_SPD) begin
            planet_x_nxt = planet_x - PLN_SPD10;
        end else begin
            planet_x_nxt = X_MAX[9:0];
            planet_y_nxt = (py_inc > Y_MAX) ? (py_inc[9:0] - Y_WRAP10) : py_inc[9:0];
        end
    end

    // ------------------------------------------------------------------
    // Frame-rate position registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            spaceship_x <= 10'd64;
            spaceship_y <= 10'd232;
            planet_x    <= 10'd624;
            planet_y    <= 10'd100;
        end else begin
            vsync_q    <= vsync_irq;
            frame_done <= vsync_rise;
            if (vsync_rise) begin
                spaceship_x <= ship_x_nxt;
                spaceship_y <= ship_y_nxt;
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt <= '0;
                    planet_x  <= planet_x_nxt;
                    planet_y  <= planet_y_nxt;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ship_motion_ctrl.sv
`timescale 1ns/1ps

module tb_ship_motion_ctrl;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic [7:0] scan_code  = 8'h00;
    logic       scan_valid = 1'b0;
    logic       vsync_irq  = 1'b0;
    logic [9:0] spaceship_x;
    logic [9:0] spaceship_y;
    logic [9:0] planet_x;
    logic [9:0] planet_y;
    logic       frame_done;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fd_cnt    = 0;
    int fd_base;

    ship_motion_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .vsync_irq   (vsync_irq),
        .spaceship_x (spaceship_x),
        .spaceship_y (spaceship_y),
        .planet_x    (planet_x),
        .planet_y    (planet_y),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // frame_done pulse counter, sampled at the active edge so it never
    // races with the stimulus driven on the falling edge
    always @(posedge clk) if (rst_n && frame_done) fd_cnt++;

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        vsync_irq  = 1'b0;
        scan_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    // one frame = vsync high one cycle, low one cycle; ends on the falling
    // edge right after the update edge
    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk);
            vsync_irq = 1'b1;
            @(negedge clk);
            vsync_irq = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h74);
        frames(3);
        total_cnt++;
        if (spaceship_x !== 10'd70) $display("FAIL pre_reset_x: got %0d expected 70", spaceship_x);
        else pass_cnt++;
        // async reset while frame_done is high, away from any edge
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (spaceship_x !== 10'd64) $display("FAIL async_rst_ship_x: got %0d expected 64", spaceship_x);
        else pass_cnt++;
        total_cnt++;
        if (spaceship_y !== 10'd232) $display("FAIL async_rst_ship_y: got %0d expected 232", spaceship_y);
        else pass_cnt++;
        total_cnt++;
        if (planet_x !== 10'd624) $display("FAIL async_rst_planet_x: got %0d expected 624", planet_x);
        else pass_cnt++;
        total_cnt++;
        if (planet_y !== 10'd100) $display("FAIL async_rst_planet_y: got %0d expected 100", planet_y);
        else pass_cnt++;
        total_cnt++;
        if (frame_done !== 1'b0) $display("FAIL async_rst_frame_done: got %0b expected 0", frame_done);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        frames(3);
        total_cnt++;
        if (spaceship_x !== 10'd64 || spaceship_y !== 10'd232)
            $display("FAIL post_rst_ship: got %0d,%0d expected 64,232", spaceship_x, spaceship_y);
        else pass_cnt++;
        total_cnt++;
        if (planet_x !== 10'd623 || planet_y !== 10'd100)
            $display("FAIL post_rst_planet: got %0d,%0d expected 623,100", planet_x, planet_y);
        else pass_cnt++;
    endtask

    task automatic test_vsync_high_out_of_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        vsync_irq = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (frame_done !== 1'b1) $display("FAIL rst_rise_frame_done: got %0b expected 1", frame_done);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (frame_done !== 1'b0) $display("FAIL rst_rise_single_pulse: got %0b expected 0", frame_done);
        else pass_cnt++;
        vsync_irq = 1'b0;
        frames(1);
        total_cnt++;
        if (planet_x !== 10'd623) $display("FAIL rst_rise_counted: got %0d expected 623", planet_x);
        else pass_cnt++;
    endtask

    task automatic test_make_break();
        do_reset();
        fd_base = fd_cnt;
        send_byte(8'hE0);
        send_byte(8'h74);
        frames(5);
        total_cnt++;
        if (spaceship_x !== 10'd74) $display("FAIL make_right_x: got %0d expected 74", spaceship_x);
        else pass_cnt++;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h74);
        frames(2);
        total_cnt++;
        if (spaceship_x !== 10'd74) $display("FAIL break_right_x: got %0d expected 74", spaceship_x);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (fd_cnt - fd_base !== 7) $display("FAIL frame_done_count: got %0d expected 7", fd_cnt - fd_base);
        else pass_cnt++;
    endtask

    // the ship moves in steps of 2 from even reset values, so the up clamp
    // is exercised from y=2
    task automatic test_clamp();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h74);
        frames(278);
        total_cnt++;
        if (spaceship_x !== 10'd620) $display("FAIL clamp_reach_620: got %0d expected 620", spaceship_x);
        else pass_cnt++;
        frames(1);
        total_cnt++;
        if (spaceship_x !== 10'd622) $display("FAIL clamp_x_622: got %0d expected 622", spaceship_x);
        else pass_cnt++;
        frames(1);
        total_cnt++;
        if (spaceship_x !== 10'd624) $display("FAIL clamp_x_624: got %0d expected 624", spaceship_x);
        else pass_cnt++;
        frames(1);
        total_cnt++;
        if (spaceship_x !== 10'd624) $display("FAIL clamp_x_hold: got %0d expected 624", spaceship_x);
        else pass_cnt++;
        total_cnt++;
        if (spaceship_y !== 10'd232) $display("FAIL clamp_y_still: got %0d expected 232", spaceship_y);
        else pass_cnt++;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h74);
        send_byte(8'hE0);
        send_byte(8'h75);
        frames(115);
        total_cnt++;
        if (spaceship_y !== 10'd2) $display("FAIL up_reach_2: got %0d expected 2", spaceship_y);
        else pass_cnt++;
        frames(1);
        total_cnt++;
        if (spaceship_y !== 10'd0) $display("FAIL up_y_0: got %0d expected 0", spaceship_y);
        else pass_cnt++;
        frames(1);
        total_cnt++;
        if (spaceship_y !== 10'd0) $display("FAIL up_y_hold: got %0d expected 0", spaceship_y);
        else pass_cnt++;
    endtask

    task automatic test_left_right();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h74);
        send_byte(8'hE0);
        send_byte(8'h6B);
        send_byte(8'hF0);
        send_byte(8'h6B);
        frames(1);
        total_cnt++;
        if (spaceship_x !== 10'd64) $display("FAIL both_keys_x: got %0d expected 64", spaceship_x);
        else pass_cnt++;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h74);
        frames(1);
        total_cnt++;
        if (spaceship_x !== 10'd62) $display("FAIL left_still_set: got %0d expected 62", spaceship_x);
        else pass_cnt++;
    endtask

    task automatic test_hold_high();
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h72);
        fd_base = fd_cnt;
        @(negedge clk);
        vsync_irq = 1'b1;
        repeat (10) @(negedge clk);
        vsync_irq = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (spaceship_y !== 10'd234) $display("FAIL hold_high_y: got %0d expected 234", spaceship_y);
        else pass_cnt++;
        total_cnt++;
        if (fd_cnt - fd_base !== 1) $display("FAIL hold_high_pulses: got %0d expected 1", fd_cnt - fd_base);
        else pass_cnt++;
        frames(1);
        total_cnt++;
        if (spaceship_y !== 10'd236) $display("FAIL rearm_y: got %0d expected 236", spaceship_y);
        else pass_cnt++;
    endtask

    // E0 and 74 on consecutive cycles, the 74 coinciding with vsync_rise
    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        scan_code  = 8'hE0;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_code  = 8'h74;
        vsync_irq  = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        vsync_irq  = 1'b0;
        total_cnt++;
        if (spaceship_x !== 10'd64) $display("FAIL coincident_old_flags: got %0d expected 64", spaceship_x);
        else pass_cnt++;
        total_cnt++;
        if (frame_done !== 1'b1) $display("FAIL coincident_frame_done: got %0b expected 1", frame_done);
        else pass_cnt++;
        frames(1);
        total_cnt++;
        if (spaceship_x !== 10'd66) $display("FAIL coincident_next_frame: got %0d expected 66", spaceship_x);
        else pass_cnt++;
    endtask

    task automatic test_planet_wrap();
        do_reset();
        frames(1248);
        total_cnt++;
        if (planet_x !== 10'd0 || planet_y !== 10'd100)
            $display("FAIL planet_reach_0: got %0d,%0d expected 0,100", planet_x, planet_y);
        else pass_cnt++;
        frames(1);
        total_cnt++;
        if (planet_x !== 10'd0) $display("FAIL planet_odd_frame_hold: got %0d expected 0", planet_x);
        else pass_cnt++;
        frames(1);
        total_cnt++;
        if (planet_x !== 10'd624 || planet_y !== 10'd197)
            $display("FAIL planet_wrap1: got %0d,%0d expected 624,197", planet_x, planet_y);
        else pass_cnt++;
        frames(1250);
        total_cnt++;
        if (planet_x !== 10'd624 || planet_y !== 10'd294)
            $display("FAIL planet_wrap2: got %0d,%0d expected 624,294", planet_x, planet_y);
        else pass_cnt++;
        frames(1250);
        total_cnt++;
        if (planet_y !== 10'd391) $display("FAIL planet_wrap3: got %0d expected 391", planet_y);
        else pass_cnt++;
        frames(1248);
        total_cnt++;
        if (planet_x !== 10'd0 || planet_y !== 10'd391)
            $display("FAIL planet_reach_0_again: got %0d,%0d expected 0,391", planet_x, planet_y);
        else pass_cnt++;
        frames(2);
        total_cnt++;
        if (planet_x !== 10'd624 || planet_y !== 10'd23)
            $display("FAIL planet_wrap_fold: got %0d,%0d expected 624,23", planet_x, planet_y);
        else pass_cnt++;
        total_cnt++;
        if (spaceship_x !== 10'd64 || spaceship_y !== 10'd232)
            $display("FAIL planet_ship_idle: got %0d,%0d expected 64,232", spaceship_x, spaceship_y);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_vsync_high_out_of_reset();
        test_make_break();
        test_clamp();
        test_left_right();
        test_hold_high();
        test_back_to_back();
        test_planet_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
